axi_write_scheduler: RTL and testbench

- Shares one AXIBurstWriteEngine between NumRequesters independent clients, e.g. trace channels draining their buffer regions to AXI memory.
- Arbitrates requests round-robin, latches the winner's (src_ptr, len, dst_ptr) and drives the engine's start handshake.
- Waits for the engine's done handshake, then returns a per-requester response.
- Sits between the tracer's channel logic and the engine; owns the engine's start/done handshake exclusively.

---
 rtl/axi_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/axi_write_scheduler.sv | 160 ++++++++++++++++
 tb/tb_axi_write_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg
// Shared types for the AXI write scheduler and its arbiter.
//   sched_state_t : scheduler FSM states.
//   sched_req_t   : request arguments latched at the accept cycle.
// The argument record is sized by the package widths below. The scheduler's
// width parameters default to these values and must match them when changed.
package axi_sched_pkg;

    localparam int SchedBufferAddrWidth = 8;
    localparam int SchedAXIAddrWidth    = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [SchedBufferAddrWidth-1:0] src;
        logic [SchedBufferAddrWidth-1:0] len;
        logic [SchedAXIAddrWidth-1:0]    dst;
    } sched_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter.
// The search starts at rr_ptr and moves upward, wrapping modulo N.
//   req       in  N     request vector
//   rr_ptr    in  IdxW  highest-priority index for this cycle
//   grant     out N     one-hot grant, or zero when no request is set
//   grant_idx out IdxW  index of the granted request (0 when none)
//   any_grant out 1     at least one request is set
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] rr_ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            any_grant
);

    // The first set bit found from rr_ptr upward wins. any_grant also serves
    // as the "already found" flag, so later hits are ignored.
    always_comb begin
        int            idx;
        logic [IdxW-1:0] idx_v;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(rr_ptr) + k) % N;
            idx_v = IdxW'(idx);
            if (!any_grant && req[idx_v]) begin
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
                any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_write_scheduler.sv
// axi_write_scheduler
// Shares one AXI burst write engine between NumRequesters clients.
// Requests are arbitrated round-robin, and only one request is in flight.
// The winner's arguments are latched and issued to the engine. After the
// engine reports done, a response is returned to the owning client.
// A zero-length request skips the engine and goes straight to the response.
//   clk, reset (async, active-low)
//   req_valid/req_ready          per-client request handshake
//   req_src_ptr/req_len/req_dst_ptr  packed per-client arguments (slice i = client i)
//   resp_valid/resp_ready        per-client completion handshake
//   eng_start_valid/ready + eng_data_ptr/eng_data_size/eng_axi_offset
//   eng_done_valid/ready         engine completion handshake
//   busy                         high outside IDLE
//   grant_id                     current owner index
module axi_write_scheduler
    import axi_sched_pkg::*;
#(
    parameter int NumRequesters   = 4,
    parameter int BufferAddrWidth = SchedBufferAddrWidth,
    parameter int AXIAddrWidth    = SchedAXIAddrWidth,
    parameter int IdWidth         = $clog2(NumRequesters)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NumRequesters-1:0]             req_valid,
    output logic [NumRequesters-1:0]             req_ready,
    input  logic [NumRequesters*BufferAddrWidth-1:0] req_src_ptr,
    input  logic [NumRequesters*BufferAddrWidth-1:0] req_len,
    input  logic [NumRequesters*AXIAddrWidth-1:0]    req_dst_ptr,
    output logic [NumRequesters-1:0]             resp_valid,
    input  logic [NumRequesters-1:0]             resp_ready,
    output logic                                 eng_start_valid,
    input  logic                                 eng_start_ready,
    output logic [BufferAddrWidth-1:0]           eng_data_ptr,
    output logic [BufferAddrWidth-1:0]           eng_data_size,
    output logic [AXIAddrWidth-1:0]              eng_axi_offset,
    input  logic                                 eng_done_valid,
    output logic                                 eng_done_ready,
    output logic                                 busy,
    output logic [IdWidth-1:0]                   grant_id
);

    sched_state_t state_q, state_d;
    logic [IdWidth-1:0] rr_ptr_q;
    logic [IdWidth-1:0] grant_id_q;
    sched_req_t         args_q;

    logic [NumRequesters-1:0] arb_grant;
    logic [IdWidth-1:0]       arb_idx;
    logic                     arb_any;
    logic                     accept;
    logic                     sel_len_zero;

    logic [BufferAddrWidth-1:0] src_arr [NumRequesters];
    logic [BufferAddrWidth-1:0] len_arr [NumRequesters];
    logic [AXIAddrWidth-1:0]    dst_arr [NumRequesters];

    // Unpack the flat per-client argument buses.
    for (genvar i = 0; i < NumRequesters; i++) begin : g_unpack
        assign src_arr[i] = req_src_ptr[i*BufferAddrWidth +: BufferAddrWidth];
        assign len_arr[i] = req_len[i*BufferAddrWidth +: BufferAddrWidth];
        assign dst_arr[i] = req_dst_ptr[i*AXIAddrWidth +: AXIAddrWidth];
    end

    rr_arbiter #(
        .N    (NumRequesters),
        .IdxW (IdWidth)
    ) u_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign accept       = (state_q == IDLE) && arb_any;
    assign sel_len_zero = (len_arr[arb_idx] == '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner, rotation pointer and arguments are captured only on the accept cycle.
    // The arguments are not sampled again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            args_q     <= '0;
        end else if (accept) begin
            grant_id_q <= arb_idx;
            rr_ptr_q   <= (arb_idx == IdWidth'(NumRequesters - 1)) ? '0
                                                                   : arb_idx + IdWidth'(1);
            args_q.src <= SchedBufferAddrWidth'(src_arr[arb_idx]);
            args_q.len <= SchedBufferAddrWidth'(len_arr[arb_idx]);
            args_q.dst <= SchedAXIAddrWidth'(dst_arr[arb_idx]);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = sel_len_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (eng_start_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_done_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready[grant_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. req_ready is also gated by reset.
    // This keeps every output at zero while reset is held, even if clients keep requesting.
    always_comb begin
        req_ready       = '0;
        resp_valid      = '0;
        eng_start_valid = 1'b0;
        eng_done_ready  = 1'b0;
        busy            = (state_q != IDLE);
        if (accept && reset) begin
            req_ready = arb_grant;
        end
        if (state_q == ISSUE) begin
            eng_start_valid = 1'b1;
        end
        if (state_q == WAIT_DONE) begin
            eng_done_ready = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid[grant_id_q] = 1'b1;
        end
    end

    assign grant_id       = grant_id_q;
    assign eng_data_ptr   = BufferAddrWidth'(args_q.src);
    assign eng_data_size  = BufferAddrWidth'(args_q.len);
    assign eng_axi_offset = AXIAddrWidth'(args_q.dst);

endmodule

// File: tb/tb_axi_write_scheduler.sv
// tb_axi_write_scheduler
// Directed bench for axi_write_scheduler with four clients.
// The engine side is driven by hand from the stimulus sequence.
module tb_axi_write_scheduler;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int AW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*BW-1:0] req_src_ptr;
    logic [N*BW-1:0] req_len;
    logic [N*AW-1:0] req_dst_ptr;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic            eng_start_valid;
    logic            eng_start_ready;
    logic [BW-1:0]   eng_data_ptr;
    logic [BW-1:0]   eng_data_size;
    logic [AW-1:0]   eng_axi_offset;
    logic            eng_done_valid;
    logic            eng_done_ready;
    logic            busy;
    logic [IW-1:0]   grant_id;

    int errors = 0;
    int checks = 0;

    axi_write_scheduler #(
        .NumRequesters   (N),
        .BufferAddrWidth (BW),
        .AXIAddrWidth    (AW),
        .IdWidth         (IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_src_ptr     (req_src_ptr),
        .req_len         (req_len),
        .req_dst_ptr     (req_dst_ptr),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .eng_start_valid (eng_start_valid),
        .eng_start_ready (eng_start_ready),
        .eng_data_ptr    (eng_data_ptr),
        .eng_data_size   (eng_data_size),
        .eng_axi_offset  (eng_axi_offset),
        .eng_done_valid  (eng_done_valid),
        .eng_done_ready  (eng_done_ready),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] rready,
                                 input logic sready, input logic dvalid);
        req_valid       = valid;
        resp_ready      = rready;
        eng_start_ready = sready;
        eng_done_valid  = dvalid;
        #1;
    endtask

    task automatic setArgs(input int i, input logic [BW-1:0] s, input logic [BW-1:0] l,
                           input logic [AW-1:0] d);
        req_src_ptr[i*BW +: BW] = s;
        req_len[i*BW +: BW]     = l;
        req_dst_ptr[i*AW +: AW] = d;
    endtask

    // Call this right after the accept edge, with the accepted client's valid dropped.
    // It needs eng_start_ready=1 and resp_ready[id]=1.
    // It walks ISSUE, WAIT_DONE and RESP, and returns in IDLE.
    task automatic serveNonZero(input int id, input logic [BW-1:0] src);
        checkOutput($sformatf("start_valid[c%0d]", id), eng_start_valid, 1);
        checkOutput($sformatf("grant_id[c%0d]", id), grant_id, id);
        checkOutput($sformatf("data_ptr[c%0d]", id), eng_data_ptr, src);
        checkOutput($sformatf("req_ready_busy[c%0d]", id), req_ready, 0);
        tick();
        checkOutput($sformatf("done_ready[c%0d]", id), eng_done_ready, 1);
        eng_done_valid = 1'b1;
        tick();
        eng_done_valid = 1'b0;
        #1;
        checkOutput($sformatf("resp_valid[c%0d]", id), resp_valid, 64'd1 << id);
        tick();
        checkOutput($sformatf("idle_after[c%0d]", id), busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        reset       = 1'b0;
        req_src_ptr = '0;
        req_len     = '0;
        req_dst_ptr = '0;
        applyStimulus('0, '1, 1'b1, 1'b0);
        #10;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start_valid", eng_start_valid, 0);
        checkOutput("rst_done_ready", eng_done_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_data_ptr", eng_data_ptr, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single client 0, engine ready immediately.
        setArgs(0, 8'h10, 8'd4, 32'h100);
        applyStimulus(4'b0001, '1, 1'b1, 1'b0);
        checkOutput("s1_req_ready", req_ready, 4'b0001);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        checkOutput("s1_start_valid", eng_start_valid, 1);
        checkOutput("s1_data_ptr", eng_data_ptr, 8'h10);
        checkOutput("s1_data_size", eng_data_size, 8'd4);
        checkOutput("s1_axi_offset", eng_axi_offset, 32'h100);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_req_ready_off", req_ready, 0);
        tick();
        checkOutput("s1_start_dropped", eng_start_valid, 0);
        checkOutput("s1_done_ready", eng_done_ready, 1);
        checkOutput("s1_no_early_resp", resp_valid, 0);
        eng_done_valid = 1'b1;
        tick();
        eng_done_valid = 1'b0;
        #1;
        checkOutput("s1_resp_valid", resp_valid, 4'b0001);
        checkOutput("s1_done_ready_off", eng_done_ready, 0);
        tick();
        checkOutput("s1_busy_off", busy, 0);
        checkOutput("s1_resp_off", resp_valid, 0);

        // Zero-length request on client 3 bypasses the engine. rr_ptr is 1, so it moves to 0.
        setArgs(3, 8'h33, 8'd0, 32'h300);
        applyStimulus(4'b1000, '1, 1'b1, 1'b0);
        checkOutput("z_req_ready", req_ready, 4'b1000);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        checkOutput("z_no_start", eng_start_valid, 0);
        checkOutput("z_resp_valid", resp_valid, 4'b1000);
        checkOutput("z_grant_id", grant_id, 3);
        tick();
        checkOutput("z_busy_off", busy, 0);
        checkOutput("z_still_no_start", eng_start_valid, 0);

        // All four clients request together, starting from rr_ptr 0.
        for (int g = 0; g < N; g++) begin
            setArgs(g, 8'h20 + 8'(g), 8'd1, 32'h1000 * g);
        end
        applyStimulus(4'b1111, '1, 1'b1, 1'b0);
        for (int g = 0; g < N; g++) begin
            checkOutput($sformatf("rr_order[%0d]", g), req_ready, 64'd1 << g);
            tick();
            req_valid[g] = 1'b0;
            #1;
            serveNonZero(g, 8'h20 + 8'(g));
        end
        // rr_ptr has wrapped to 0, so client 0 beats client 1.
        applyStimulus(4'b0011, '1, 1'b1, 1'b0);
        checkOutput("rr_wrap", req_ready, 4'b0001);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        serveNonZero(0, 8'h20);

        // Fairness: client 2 requests continuously and client 1 requests once.
        applyStimulus(4'b0100, '1, 1'b1, 1'b0);
        checkOutput("fair_first", req_ready, 4'b0100);
        tick();
        applyStimulus(4'b0110, '1, 1'b1, 1'b0);
        serveNonZero(2, 8'h22);
        checkOutput("fair_second", req_ready, 4'b0010);
        tick();
        applyStimulus(4'b0100, '1, 1'b1, 1'b0);
        serveNonZero(1, 8'h21);
        checkOutput("fair_third", req_ready, 4'b0100);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        serveNonZero(2, 8'h22);

        // Engine and response stalls on client 0. Client 1 waits throughout.
        setArgs(0, 8'h55, 8'd9, 32'hDEADBEE0);
        applyStimulus(4'b0001, '1, 1'b0, 1'b0);
        checkOutput("st_req_ready", req_ready, 4'b0001);
        tick();
        applyStimulus(4'b0010, '1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("st_issue_valid[%0d]", i), eng_start_valid, 1);
            checkOutput($sformatf("st_issue_ptr[%0d]", i), eng_data_ptr, 8'h55);
            checkOutput($sformatf("st_issue_size[%0d]", i), eng_data_size, 8'd9);
            checkOutput($sformatf("st_issue_off[%0d]", i), eng_axi_offset, 32'hDEADBEE0);
            checkOutput($sformatf("st_issue_rdy[%0d]", i), req_ready, 0);
            checkOutput($sformatf("st_issue_dready[%0d]", i), eng_done_ready, 0);
            tick();
        end
        eng_start_ready = 1'b1;
        #1;
        checkOutput("st_issue_last", eng_start_valid, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("st_wait_dready[%0d]", i), eng_done_ready, 1);
            checkOutput($sformatf("st_wait_svalid[%0d]", i), eng_start_valid, 0);
            checkOutput($sformatf("st_wait_ptr[%0d]", i), eng_data_ptr, 8'h55);
            checkOutput($sformatf("st_wait_off[%0d]", i), eng_axi_offset, 32'hDEADBEE0);
            checkOutput($sformatf("st_wait_rdy[%0d]", i), req_ready, 0);
            tick();
        end
        eng_done_valid = 1'b1;
        tick();
        applyStimulus(4'b0010, 4'b1110, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("st_resp_hold[%0d]", i), resp_valid, 4'b0001);
            checkOutput($sformatf("st_resp_busy[%0d]", i), busy, 1);
            checkOutput($sformatf("st_resp_rdy[%0d]", i), req_ready, 0);
            tick();
        end
        resp_ready = '1;
        #1;
        checkOutput("st_resp_final", resp_valid, 4'b0001);
        tick();
        checkOutput("st_back_to_back", req_ready, 4'b0010);
        checkOutput("st_idle", busy, 0);
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        tick();

        // Reset during WAIT_DONE. rr_ptr is 1 before the grant to client 1.
        setArgs(1, 8'h11, 8'd2, 32'h110);
        applyStimulus(4'b0010, '1, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        tick();
        checkOutput("ar_in_wait", eng_done_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_start_valid", eng_start_valid, 0);
        checkOutput("ar_done_ready", eng_done_ready, 0);
        checkOutput("ar_data_ptr", eng_data_ptr, 0);
        checkOutput("ar_data_size", eng_data_size, 0);
        checkOutput("ar_axi_offset", eng_axi_offset, 0);
        checkOutput("ar_grant_id", grant_id, 0);
        checkOutput("ar_resp_valid", resp_valid, 0);
        tick();
        tick();
        checkOutput("ar_no_resp", resp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        // With rr_ptr back at 0, client 1 wins over client 3.
        applyStimulus(4'b1010, '1, 1'b1, 1'b0);
        checkOutput("ar_regrant", req_ready, 4'b0010);
        tick();
        applyStimulus(4'b0000, '1, 1'b1, 1'b0);
        checkOutput("ar_regrant_size", eng_data_size, 8'd2);
        serveNonZero(1, 8'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
